// File: rtl/mirfak_div_dispatch.sv
// Pipeline-side control for mirfak_divider: resolves RISC-V divide corner cases locally
// and sequences the divider enable. Optional one-entry result cache: MIRFAK_DIV_CACHE_EN.
//   state | meaning
//   IDLE  | waiting for a request
//   FAST  | result known locally, ack this cycle unless killed
//   WAIT  | divider running for a live request
//   DRAIN | request killed, divider still running
//   GAP   | enable low one cycle so the divider re-arms
module mirfak_div_dispatch (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] md_op1_i,
   input  logic [31:0] md_op2_i,
   input  logic [1:0]  md_cmd_i,
   input  logic        md_valid_i,
   input  logic        md_kill_i,
   output logic [31:0] md_result_o,
   output logic        md_ack_o,
   output logic        md_busy_o,
   output logic [31:0] div_op1,
   output logic [31:0] div_op2,
   output logic [1:0]  div_cmd,
   output logic        div_enable,
   input  logic [31:0] div_result,
   input  logic        div_ack
);

   typedef enum logic [2:0] {ST_IDLE, ST_FAST, ST_WAIT, ST_DRAIN, ST_GAP} state_t;

   state_t      state_q, state_d;
   logic [31:0] md_result_q, md_result_d;
   logic        md_ack_q, md_ack_d;
   logic [31:0] div_op1_q, div_op1_d;
   logic [31:0] div_op2_q, div_op2_d;
   logic [1:0]  div_cmd_q, div_cmd_d;
   logic        div_enable_q, div_enable_d;

   logic        op2_zero, sgn_ovf, is_rem, corner;
   logic [31:0] corner_res;
   logic        cache_hit;
   logic [31:0] cache_res;

   assign op2_zero = (md_op2_i == 32'h0);
   assign sgn_ovf  = !md_cmd_i[0] && (md_op1_i == 32'h8000_0000) && (md_op2_i == 32'hFFFF_FFFF);
   assign is_rem   = md_cmd_i[1];
   assign corner   = op2_zero || sgn_ovf;

   always_comb begin
      corner_res = 32'h0;
      if (op2_zero) corner_res = is_rem ? md_op1_i : 32'hFFFF_FFFF;
      else if (sgn_ovf) corner_res = is_rem ? 32'h0 : 32'h8000_0000;
   end

`ifdef MIRFAK_DIV_CACHE_EN
   logic [31:0] cache_op1_q, cache_op1_d;
   logic [31:0] cache_op2_q, cache_op2_d;
   logic [31:0] cache_res_q, cache_res_d;
   logic [1:0]  cache_cmd_q, cache_cmd_d;
   logic        cache_vld_q, cache_vld_d;

   // Only a live divider completion is trusted to fill the entry.
   always_comb begin
      cache_op1_d = cache_op1_q;
      cache_op2_d = cache_op2_q;
      cache_cmd_d = cache_cmd_q;
      cache_res_d = cache_res_q;
      cache_vld_d = cache_vld_q;
      if (state_q == ST_WAIT && div_ack && !md_kill_i) begin
         cache_op1_d = div_op1_q;
         cache_op2_d = div_op2_q;
         cache_cmd_d = div_cmd_q;
         cache_res_d = div_result;
         cache_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cache_op1_q <= 32'h0;
         cache_op2_q <= 32'h0;
         cache_cmd_q <= 2'b00;
         cache_res_q <= 32'h0;
         cache_vld_q <= 1'b0;
      end else begin
         cache_op1_q <= cache_op1_d;
         cache_op2_q <= cache_op2_d;
         cache_cmd_q <= cache_cmd_d;
         cache_res_q <= cache_res_d;
         cache_vld_q <= cache_vld_d;
      end
   end

   assign cache_hit = cache_vld_q && (cache_op1_q == md_op1_i) && (cache_op2_q == md_op2_i)
                      && (cache_cmd_q == md_cmd_i);
   assign cache_res = cache_res_q;
`else
   assign cache_hit = 1'b0;
   assign cache_res = 32'h0;
`endif

   always_comb begin
      state_d      = state_q;
      md_result_d  = md_result_q;
      md_ack_d     = 1'b0;
      div_op1_d    = div_op1_q;
      div_op2_d    = div_op2_q;
      div_cmd_d    = div_cmd_q;
      div_enable_d = div_enable_q;
      case (state_q)
         ST_IDLE: begin
            if (md_valid_i && !md_kill_i) begin
               if (corner) begin
                  md_result_d = corner_res;
                  state_d     = ST_FAST;
               end else if (cache_hit) begin
                  md_result_d = cache_res;
                  state_d     = ST_FAST;
               end else begin
                  div_op1_d    = md_op1_i;
                  div_op2_d    = md_op2_i;
                  div_cmd_d    = md_cmd_i;
                  div_enable_d = 1'b1;
                  state_d      = ST_WAIT;
               end
            end
         end
         ST_FAST: state_d = ST_IDLE;
         ST_WAIT: begin
            if (div_ack) begin
               div_enable_d = 1'b0;
               state_d      = ST_GAP;
               if (!md_kill_i) begin
                  md_result_d = div_result;
                  md_ack_d    = 1'b1;
               end
            end else if (md_kill_i) begin
               state_d = ST_DRAIN;
            end
         end
         // The divider cannot abort, so enable stays up until it finishes.
         ST_DRAIN: begin
            if (div_ack) begin
               div_enable_d = 1'b0;
               state_d      = ST_GAP;
            end
         end
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         md_result_q  <= 32'h0;
         md_ack_q     <= 1'b0;
         div_op1_q    <= 32'h0;
         div_op2_q    <= 32'h0;
         div_cmd_q    <= 2'b00;
         div_enable_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         md_result_q  <= md_result_d;
         md_ack_q     <= md_ack_d;
         div_op1_q    <= div_op1_d;
         div_op2_q    <= div_op2_d;
         div_cmd_q    <= div_cmd_d;
         div_enable_q <= div_enable_d;
      end
   end

   // A fast-path ack is combinational so a kill in that same cycle can still cancel it.
   assign md_ack_o    = md_ack_q || (state_q == ST_FAST && !md_kill_i);
   assign md_result_o = md_result_q;
   assign md_busy_o   = (state_q != ST_IDLE);
   assign div_op1     = div_op1_q;
   assign div_op2     = div_op2_q;
   assign div_cmd     = div_cmd_q;
   assign div_enable  = div_enable_q;

endmodule

// File: tb/tb_mirfak_div_dispatch.sv
// Randomised bench for mirfak_div_dispatch with a behavioural divider and result model.
module tb_mirfak_div_dispatch;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] md_op1_i, md_op2_i;
   logic [1:0]  md_cmd_i;
   logic        md_valid_i, md_kill_i;
   logic [31:0] md_result_o;
   logic        md_ack_o, md_busy_o;
   logic [31:0] div_op1, div_op2;
   logic [1:0]  div_cmd;
   logic        div_enable;
   logic [31:0] div_result;
   logic        div_ack;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int exp_ack_cyc = -1;
   logic [31:0] exp_res = 32'h0;
   int dv_lat = 4;

   // model cache
   logic        mc_vld = 1'b0;
   logic [31:0] mc_op1 = 32'h0, mc_op2 = 32'h0, mc_res = 32'h0;
   logic [1:0]  mc_cmd = 2'b00;

   mirfak_div_dispatch dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .md_op1_i(md_op1_i), .md_op2_i(md_op2_i), .md_cmd_i(md_cmd_i),
      .md_valid_i(md_valid_i), .md_kill_i(md_kill_i),
      .md_result_o(md_result_o), .md_ack_o(md_ack_o), .md_busy_o(md_busy_o),
      .div_op1(div_op1), .div_op2(div_op2), .div_cmd(div_cmd), .div_enable(div_enable),
      .div_result(div_result), .div_ack(div_ack)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%h want=%h (cycle %0d)", nm, got, want, cyc);
      end
   endtask

   // RISC-V M-extension divide semantics.
   function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] c);
      int sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      case (c)
         2'b00: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(sa / sb);
         end
         2'b01: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         2'b10: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(sa % sb);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_corner(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c);
      return (b == 0) || (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic bit mc_hit(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c);
`ifdef MIRFAK_DIV_CACHE_EN
      return mc_vld && mc_op1 == a && mc_op2 == b && mc_cmd == c;
`else
      return 1'b0;
`endif
   endfunction

   // Behavioural divider: captures operands when enable rises, acks once after dv_lat cycles.
   initial begin : divider_model
      logic        prev_en;
      int          cnt;
      bit          done;
      logic [31:0] cap1, cap2;
      logic [1:0]  capc;
      div_ack = 1'b0; div_result = 32'h0;
      prev_en = 1'b0; cnt = 0; done = 1'b0;
      cap1 = 32'h0; cap2 = 32'h0; capc = 2'b00;
      forever begin
         @(posedge clk_i); #1;
         div_ack = 1'b0;
         if (rst_i || !div_enable) begin
            cnt = 0; done = 1'b0;
         end else begin
            if (!prev_en) begin
               cnt = 1; cap1 = div_op1; cap2 = div_op2; capc = div_cmd;
            end else begin
               cnt++;
               chk("div_ops_stable", {div_op1[15:0], div_op2[13:0], div_cmd}, {cap1[15:0], cap2[13:0], capc});
            end
            if (!done && cnt == dv_lat) begin
               div_ack = 1'b1;
               div_result = ref_res(cap1, cap2, capc);
               done = 1'b1;
            end
         end
         prev_en = div_enable && !rst_i;
      end
   end

   always @(negedge clk_i) begin
      if (!rst_i) begin
         n_checks++;
         if (md_ack_o !== (cyc == exp_ack_cyc)) begin
            n_fail++;
            $display("FAIL ack_timing got=%b want=%b (cycle %0d)", md_ack_o, (cyc == exp_ack_cyc), cyc);
         end else if (md_ack_o && md_result_o !== exp_res) begin
            n_fail++;
            $display("FAIL ack_result got=%h want=%h (cycle %0d)", md_result_o, exp_res, cyc);
         end
      end
   end

   task automatic do_reset();
      rst_i = 1'b1; md_valid_i = 1'b0; md_kill_i = 1'b0;
      exp_ack_cyc = -1; mc_vld = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
   endtask

   // kmode: 0 none, 1 kill in WAIT at accept+kofs, 2 kill with div_ack, 3 kill in FAST, 4 kill at request
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c,
                        input int kmode_in, input int kofs);
      bit fast, got;
      int kmode, acc, i;
      logic [31:0] r;
      fast  = is_corner(a, b, c) || mc_hit(a, b, c);
      r     = ref_res(a, b, c);
      kmode = kmode_in;
      if (fast && (kmode == 1 || kmode == 2)) kmode = 0;
      if (!fast && kmode == 3) kmode = 0;
      dv_lat = (kmode == 1) ? kofs + 1 + $urandom_range(0, 3) : $urandom_range(3, 8);
      md_op1_i = a; md_op2_i = b; md_cmd_i = c;
      md_valid_i = 1'b1; md_kill_i = (kmode == 4);
      acc = cyc;
      @(posedge clk_i); #1;
      if (kmode == 4) begin
         md_valid_i = 1'b0; md_kill_i = 1'b0;
         chk("killed_req_busy", md_busy_o, 1'b0);
         chk("killed_req_enable", div_enable, 1'b0);
         return;
      end
      chk("accept_busy", md_busy_o, 1'b1);
      if (fast) begin
         if (kmode == 3) md_kill_i = 1'b1;
         else begin exp_ack_cyc = acc + 1; exp_res = r; end
         md_valid_i = 1'b0;
         chk("fast_no_enable", div_enable, 1'b0);
         @(posedge clk_i); #1;
         md_kill_i = 1'b0;
         chk("fast_idle_busy", md_busy_o, 1'b0);
         return;
      end
      chk("div_enable_rise", div_enable, 1'b1);
      got = 1'b0; i = 0;
      while (!got && i < 60) begin
         md_kill_i = (kmode == 1 && cyc == acc + kofs);
         if (md_kill_i) md_valid_i = 1'b0;
         #1;
         if (div_ack) got = 1'b1;
         else begin @(posedge clk_i); #1; i++; end
      end
      if (!got) begin
         n_checks++; n_fail++;
         $display("FAIL div_ack_timeout got=none want=ack within 60 cycles");
         do_reset();
         return;
      end
      if (kmode == 2) begin
         md_kill_i = 1'b1; md_valid_i = 1'b0;
      end else if (kmode == 0) begin
         exp_ack_cyc = cyc + 1; exp_res = r;
         mc_vld = 1'b1; mc_op1 = a; mc_op2 = b; mc_cmd = c; mc_res = r;
      end
      @(posedge clk_i); #1;
      md_kill_i = 1'b0; md_valid_i = 1'b0;
      chk("gap_enable_low", div_enable, 1'b0);
      chk("gap_busy", md_busy_o, 1'b1);
      @(posedge clk_i); #1;
      chk("post_gap_idle", md_busy_o, 1'b0);
   endtask

   function automatic logic [31:0] pick_op();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         4: return 32'h0 - 32'($urandom_range(1, 20));
         default: return $urandom();
      endcase
   endfunction

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [31:0] a, b;
      logic [1:0]  c;
      int          m, sel;
      md_op1_i = 32'h0; md_op2_i = 32'h0; md_cmd_i = 2'b00;
      do_reset();
      chk("rst_ack", md_ack_o, 1'b0);
      chk("rst_result", md_result_o, 32'h0);
      chk("rst_busy", md_busy_o, 1'b0);
      chk("rst_enable", div_enable, 1'b0);
      chk("rst_div_op1", div_op1, 32'h0);
      chk("rst_div_op2", div_op2, 32'h0);
      chk("rst_div_cmd", div_cmd, 2'b00);

      chk("model_div_neg", ref_res(32'hFFFF_FFEC, 32'd6, 2'b00), 32'hFFFF_FFFD);
      chk("model_remu_zero", ref_res(32'd7, 32'd0, 2'b11), 32'd7);
      chk("model_div_ovf", ref_res(32'h8000_0000, 32'hFFFF_FFFF, 2'b00), 32'h8000_0000);
      chk("model_rem_ovf", ref_res(32'h8000_0000, 32'hFFFF_FFFF, 2'b10), 32'h0);
      chk("model_rem", ref_res(32'd100, 32'd7, 2'b10), 32'd2);
      chk("model_divu", ref_res(32'd1000, 32'd10, 2'b01), 32'd100);

      do_op(32'hFFFF_FFEC, 32'd6, 2'b00, 0, 0);
      do_op(32'd7, 32'd0, 2'b11, 0, 0);
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 0, 0);
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 0, 0);
      do_op(32'd100, 32'd7, 2'b01, 1, 5);
      do_op(32'd100, 32'd7, 2'b10, 0, 0);
      do_op(32'd55, 32'd4, 2'b01, 2, 0);
      do_op(32'd10, 32'd3, 2'b01, 0, 0);
      do_op(32'd9, 32'd3, 2'b01, 0, 0);
      do_op(32'd1000, 32'd10, 2'b01, 0, 0);
      do_op(32'd1000, 32'd10, 2'b01, 0, 0);
      do_reset();
      do_op(32'd1000, 32'd10, 2'b01, 0, 0);
      do_op(32'd5, 32'd0, 2'b00, 3, 0);
      do_op(32'd20, 32'd3, 2'b01, 4, 0);

      // reset while the divider is running
      md_op1_i = 32'd77; md_op2_i = 32'd5; md_cmd_i = 2'b01; md_valid_i = 1'b1; dv_lat = 8;
      repeat (3) @(posedge clk_i);
      do_reset();
      chk("midop_rst_enable", div_enable, 1'b0);
      chk("midop_rst_busy", md_busy_o, 1'b0);
      chk("midop_rst_op1", div_op1, 32'h0);

      a = 32'h0; b = 32'h1; c = 2'b00;
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 3) != 0) begin
            a = pick_op(); b = pick_op(); c = 2'($urandom_range(0, 3));
         end
         sel = $urandom_range(0, 9);
         m = (sel < 4) ? sel + 1 : 0;
         do_op(a, b, c, m, $urandom_range(1, 6));
         if ($urandom_range(0, 49) == 0) do_reset();
      end

      repeat (3) @(posedge clk_i);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
